timer_irq: RTL and testbench
============================

# timer_irq

Programmable interval timer driven by the control unit's timer instruction (opcode 101000, fields enable[9], base[8:6], umbral[5:0]). It receives the configuration word, divides the clock by a power-of-two prescaler and counts prescaled ticks up to the threshold. On each expiry it raises a level interrupt request that feeds one of the CPU's interrupt-enable inputs, and holds it until the CPU acknowledges. The block sits beside the datapath and is written only through the instruction decode path.

## Interface
- PRESC_W, 7, prescaler counter width; must be ≥ 7 so the maximum base of 7 (period 128) fits
- UMB_W, 6, threshold and count width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset asynchronous and active-low
- cfg_we  in  1  one-cycle strobe, timer instruction executing
- cfg  in  10  instruction bits [9:0]: enable=cfg[9], base=cfg[8:6], umbral=cfg[5:0]
- irq_ack  in  1  one-cycle acknowledge from CPU interrupt service
- irq  out  1  pending interrupt request (level)
- overrun  out  1  sticky: expiry occurred while irq already pending
- running  out  1  high in state RUN
- count  out  UMB_W  current tick count

## Operation
- Reset (async, reset=0): state IDLE; irq=0, overrun=0, running=0, count=0, prescaler=0, stored base=0, stored umbral=0.
- States: IDLE, RUN.
- cfg_we=1 (any state):
  - Latch base and umbral.
  - Clear prescaler and count.
  - Next state is RUN if enable=1 and umbral≠0, else IDLE.
  - enable=0 also clears irq and overrun; enable=1 leaves a pending irq untouched.
- IDLE: counters frozen, no expiry.
- RUN:
  - Tick when prescaler == 2^base−1; prescaler←0 on tick, else prescaler+1. base=0 gives a tick every cycle; base=7 gives one every 128 cycles.
  - On tick: if count == umbral−1 then count←0 and expiry fires, else count+1.
  - Periodic: RUN continues after expiry with no reload needed.
- Expiry: if irq=0 then irq←1; if irq=1 and no ack in the same cycle then overrun←1.
- irq_ack: clears irq. Same-cycle ack and expiry: irq stays 1 (new event wins), overrun not set.
- overrun is cleared only by reset or cfg_we with enable=0.
- cfg_we in the same cycle as a tick: cfg_we wins; that tick is discarded.
- irq_ack in IDLE or with irq=0: no effect.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Take the cfg_we edge as edge 0. irq rises after edge umbral·2^base and repeats every umbral·2^base cycles.
  - base=0, umbral=3: irq high after edge 3.
  - base=2, umbral=2: irq high after edge 8.
- running is high from edge 0 (after the clock edge) when configured enabled.
- irq falls one edge after irq_ack is sampled high.
- Reset mid-count: outputs go to reset values immediately, without waiting for clk. The block stays IDLE after reset release until the next cfg_we.
- count changes only on tick edges and is visible one edge after the tick.

## Test plan
- Reset, then cfg=10'b1_000_000011 strobe: irq=1 after edge 3, count sequence 1,2,0; ack at edge 4 gives irq=0 after edge 4; next irq after edge 6.
- cfg enable=1, base=2, umbral=2: count increments every 4 cycles; irq after edge 8; running=1 throughout.
- umbral=1, base=0, no ack: irq=1 after edge 1, overrun=1 after edge 2; cfg_we with enable=0 gives irq=0, overrun=0, running=0.
- Ack asserted on the exact expiry edge (base=0, umbral=2, ack at edge 4): irq remains 1, overrun remains 0.
- Reconfigure mid-count (umbral=5, at count=3 write umbral=2): count←0, irq after 2 further ticks, no expiry from the old setting. Second case: cfg_we coinciding with a tick gives count=0, not 1.
- Assert reset=0 asynchronously between edges during RUN with irq=1: irq, overrun, running, count all 0 immediately; after release the block stays IDLE with no irq for ≥ 200 cycles.

Source files
------------

// File: rtl/timer_irq.sv
// timer_irq: programmable interval timer written by the timer instruction.
//
// A configuration word selects a power-of-two prescaler (base) and a tick
// threshold (umbral). While running, the prescaler divides the clock and
// prescaled ticks are counted modulo umbral. Each wrap of the count is an
// expiry, which raises a level interrupt held until the CPU acknowledges.
//
// Ports:
//   clk_i       system clock, all state on the rising edge
//   rst_ni      asynchronous active-low reset
//   cfg_we_i    one-cycle strobe, timer instruction executing
//   cfg_i       instruction bits [9:0]: enable=[9], base=[8:6], umbral=[5:0]
//   irq_ack_i   one-cycle acknowledge from the interrupt service routine
//   irq_o       pending interrupt request (level)
//   overrun_o   sticky flag: expiry occurred while irq was already pending
//   running_o   high while the timer is in the run state
//   count_o     current prescaled tick count
module timer_irq #(
  parameter int unsigned PRESC_W = 7,
  parameter int unsigned UMB_W   = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_we_i,
  input  logic [9:0]       cfg_i,
  input  logic             irq_ack_i,
  output logic             irq_o,
  output logic             overrun_o,
  output logic             running_o,
  output logic [UMB_W-1:0] count_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [UMB_W-1:0]     count_q, count_d;
  logic [2:0]           base_q, base_d;
  logic [UMB_W-1:0]     umbral_q, umbral_d;
  logic                 irq_q, irq_d;
  logic                 overrun_q, overrun_d;

  // Configuration word fields.
  logic                 cfg_en;
  logic [2:0]           cfg_base;
  logic [UMB_W-1:0]     cfg_umbral;

  assign cfg_en     = cfg_i[9];
  assign cfg_base   = cfg_i[8:6];
  assign cfg_umbral = UMB_W'(cfg_i[5:0]);

  // Prescaler terminal value 2^base - 1, built as a mask so base=7 gives 127
  // without needing a wider intermediate.
  logic [PRESC_W-1:0]   presc_lim;
  logic                 tick;
  logic                 count_last;

  assign presc_lim  = ~({PRESC_W{1'b1}} << base_q);
  assign tick       = (state_q == StRun) && (presc_q == presc_lim);
  // umbral is never zero in the run state, so umbral-1 cannot wrap here.
  assign count_last = (count_q == (umbral_q - UMB_W'(1)));

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    count_d   = count_q;
    base_d    = base_q;
    umbral_d  = umbral_q;
    irq_d     = irq_q;
    overrun_d = overrun_q;

    if (cfg_we_i) begin
      // A configuration write overrides any tick in the same cycle.
      base_d   = cfg_base;
      umbral_d = cfg_umbral;
      presc_d  = '0;
      count_d  = '0;
      state_d  = (cfg_en && (cfg_umbral != '0)) ? StRun : StIdle;
      if (!cfg_en) begin
        irq_d     = 1'b0;
        overrun_d = 1'b0;
      end else if (irq_ack_i) begin
        irq_d = 1'b0;
      end
    end else begin
      if (irq_ack_i) begin
        irq_d = 1'b0;
      end
      if (tick) begin
        presc_d = '0;
        if (count_last) begin
          count_d = '0;
          // A new expiry wins over a same-cycle acknowledge.
          irq_d   = 1'b1;
          if (irq_q && !irq_ack_i) begin
            overrun_d = 1'b1;
          end
        end else begin
          count_d = count_q + UMB_W'(1);
        end
      end else if (state_q == StRun) begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      count_q   <= '0;
      base_q    <= '0;
      umbral_q  <= '0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      base_q    <= base_d;
      umbral_q  <= umbral_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq_o     = irq_q;
  assign overrun_o = overrun_q;
  assign running_o = (state_q == StRun);
  assign count_o   = count_q;

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: directed scenarios followed by random
// configuration writes, acknowledges and asynchronous resets. A reference
// model derives the expected outputs from elapsed cycles since the last
// configuration write; a monitor compares them against the DUT.
module tb_timer_irq;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [9:0] cfg;
  logic       irq_ack;
  logic       irq;
  logic       overrun;
  logic       running;
  logic [5:0] count;

  timer_irq #(
    .PRESC_W(7),
    .UMB_W  (6)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .cfg_we_i (cfg_we),
    .cfg_i    (cfg),
    .irq_ack_i(irq_ack),
    .irq_o    (irq),
    .overrun_o(overrun),
    .running_o(running),
    .count_o  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       irq;
    logic       ovr;
    logic       run;
    logic [5:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: cycles elapsed in run since the last write.
  bit   m_run, m_irq, m_ovr, m_exp;
  int   m_base, m_umb, m_n;
  obs_t m_e;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run  = 0;
      m_irq  = 0;
      m_ovr  = 0;
      m_base = 0;
      m_umb  = 0;
      m_n    = 0;
    end else if (cfg_we) begin
      m_base = int'(cfg[8:6]);
      m_umb  = int'(cfg[5:0]);
      m_n    = 0;
      m_run  = cfg[9] && (m_umb != 0);
      if (!cfg[9]) begin
        m_irq = 0;
        m_ovr = 0;
      end else if (irq_ack) begin
        m_irq = 0;
      end
    end else begin
      m_exp = 0;
      if (m_run) begin
        m_n++;
        if (m_n % (m_umb * (1 << m_base)) == 0) m_exp = 1;
      end
      if (m_exp) begin
        if (m_irq && !irq_ack) m_ovr = 1;
        m_irq = 1;
      end else if (irq_ack) begin
        m_irq = 0;
      end
    end
    m_e.irq = m_irq;
    m_e.ovr = m_ovr;
    m_e.run = m_run;
    m_e.cnt = m_run ? 6'((m_n >> m_base) % m_umb) : 6'd0;
    exp_q.push_back(m_e);
  end

  // Monitor: outputs are registered, so sample just after each edge and
  // just after an asynchronous reset assertion.
  obs_t act, want;
  always begin
    @(posedge clk or negedge rst_n);
    #1;
    act.irq = irq;
    act.ovr = overrun;
    act.run = running;
    act.cnt = count;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow @%0t: got output with no expected entry", $time);
    end else begin
      want = exp_q.pop_front();
      if (act !== want) begin
        errors++;
        $display("FAIL outputs @%0t: got irq=%b ovr=%b run=%b cnt=%0d, want irq=%b ovr=%b run=%b cnt=%0d",
                 $time, act.irq, act.ovr, act.run, act.cnt,
                 want.irq, want.ovr, want.run, want.cnt);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a write sampled on the next rising edge (edge 0).
  task automatic cfg_write(input bit en, input int b, input int u);
    cfg_we = 1'b1;
    cfg    = {en, 3'(b), 6'(u)};
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  // Assert reset between edges, release on the following falling edge.
  task automatic async_reset();
    cfg_we  = 1'b0;
    irq_ack = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int r;
  int b;

  initial begin
    cfg_we  = 1'b0;
    cfg     = '0;
    irq_ack = 1'b0;
    rst_n   = 1'b1;
    #3 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // base=0, umbral=3; ack sampled at edge 4, next expiry at edge 6.
    cfg_write(1'b1, 0, 3);
    idle(3);
    ack_pulse();
    idle(4);

    // base=2, umbral=2: tick every 4 cycles, expiry at edge 8.
    cfg_write(1'b1, 2, 2);
    idle(10);
    ack_pulse();

    // umbral=1, no ack: overrun, then disable clears everything.
    cfg_write(1'b1, 0, 1);
    idle(3);
    cfg_write(1'b0, 0, 1);
    idle(2);

    // Ack on the exact expiry edge (edge 4).
    cfg_write(1'b1, 0, 2);
    idle(3);
    ack_pulse();
    idle(3);

    // Reconfigure mid-count, then a write coinciding with a tick.
    cfg_write(1'b0, 0, 0);
    cfg_write(1'b1, 0, 5);
    idle(3);
    cfg_write(1'b1, 0, 2);
    idle(3);
    cfg_write(1'b1, 2, 5);
    idle(7);
    cfg_write(1'b1, 2, 3);
    idle(14);

    // enable with umbral=0 stays idle; largest prescaler.
    cfg_write(1'b0, 0, 0);
    cfg_write(1'b1, 3, 0);
    idle(4);
    cfg_write(1'b1, 7, 2);
    idle(260);
    ack_pulse();

    // Asynchronous reset while running with irq pending, then 200 idle cycles.
    cfg_write(1'b1, 0, 1);
    idle(3);
    async_reset();
    for (int i = 0; i < 200; i++) begin
      irq_ack = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    irq_ack = 1'b0;

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        async_reset();
      end else begin
        b       = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 3);
        cfg_we  = ($urandom_range(0, 29) == 0);
        cfg     = {($urandom_range(0, 7) != 0), 3'(b), 6'($urandom_range(0, 6))};
        irq_ack = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
    end
    cfg_we  = 1'b0;
    irq_ack = 1'b0;
    idle(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
